// File: rtl/seq_det_pkg.sv
// Shared types for the "110" serial detector and its word scheduler.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } dstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sched_t;

endpackage

// File: rtl/det110_core.sv
// Moore/Mealy "110" detector; advances only on bit_en, holds otherwise.
module det110_core
    import seq_det_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    bit_en,
    input  logic    bit_in,
    output dstate_t dstate,
    output logic    out_mo,
    output logic    out_me
);

    dstate_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S0;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bit_en) begin
            unique case (state_q)
                S0: state_d = bit_in ? S1 : S0;
                S1: state_d = bit_in ? S2 : S0;
                S2: state_d = bit_in ? S2 : S3;
                S3: state_d = bit_in ? S1 : S0;
            endcase
        end
    end

    assign dstate = state_q;
    assign out_mo = (state_q == S3);
    assign out_me = bit_en & (state_q == S2) & ~bit_in;

endmodule

// File: rtl/seq_detect_sched.sv
// Word-to-bit scheduler feeding det110_core, with match counter and
// sticky threshold interrupt.
module seq_detect_sched
    import seq_det_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [CNT_W-1:0]  thresh,
    input  logic              clr,
    output logic              busy,
    output logic              det_bit,
    output logic              bit_en,
    output logic              det_mo,
    output logic              det_me,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              irq
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sched_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              irq_q, irq_d;
    logic              last, take;
    dstate_t           dstate;

    assign busy     = (state_q == SHIFT);
    assign last     = busy && (idx_q == '0);
    assign in_ready = ~rst & (~busy | last);
    assign take     = in_valid & in_ready;
    assign bit_en   = busy;
    assign det_bit  = busy & shreg_q[WORD_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    shreg_d = in_data;
                    idx_d   = IDX_W'(WORD_W - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = shreg_q << 1;
                idx_d   = idx_q - 1'b1;
                // Reload on the last bit keeps the stream gapless
                if (last) begin
                    if (take) begin
                        shreg_d = in_data;
                        idx_d   = IDX_W'(WORD_W - 1);
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        irq_d = irq_q;
        if (clr) begin
            cnt_d = '0;
            irq_d = 1'b0;
        end else begin
            if (det_me && cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
            if (thresh != '0 && cnt_d == thresh)
                irq_d = 1'b1;
        end
    end

    det110_core u_core (
        .clk   (clk),
        .rst   (rst),
        .bit_en(bit_en),
        .bit_in(det_bit),
        .dstate(dstate),
        .out_mo(det_mo),
        .out_me(det_me)
    );

    assign match_cnt = cnt_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched; a second CNT_W=2 instance
// shares the stimulus and is used to observe counter saturation.
module tb_seq_detect_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic [7:0] thresh = '0;
    logic       clr = 1'b0;

    logic       in_ready, busy, det_bit, bit_en, det_mo, det_me, irq;
    logic [7:0] match_cnt;

    logic       s_in_ready, s_busy, s_det_bit, s_bit_en;
    logic       s_det_mo, s_det_me, s_irq;
    logic [1:0] s_match_cnt;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    seq_detect_sched #(.WORD_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .thresh(thresh), .clr(clr), .busy(busy),
        .det_bit(det_bit), .bit_en(bit_en), .det_mo(det_mo),
        .det_me(det_me), .match_cnt(match_cnt), .irq(irq)
    );

    seq_detect_sched #(.WORD_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .thresh(2'd0), .clr(clr), .busy(s_busy),
        .det_bit(s_det_bit), .bit_en(s_bit_en), .det_mo(s_det_mo),
        .det_me(s_det_me), .match_cnt(s_match_cnt), .irq(s_irq)
    );

    // Hand a word over and record per-bit-cycle outputs (bit k = MSB-first index k).
    // On return the bench sits at the negedge of the last-bit cycle.
    task automatic shift_word(
        input  logic [7:0] w,
        input  logic       keep_valid,
        input  logic [7:0] nxt,
        output logic [7:0] me_v,
        output logic [7:0] mo_v,
        output logic [7:0] rdy_v,
        output logic [7:0] bsy_v,
        output logic [7:0] irq_v,
        output logic [7:0] bit_v
    );
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        if (keep_valid) in_data = nxt;
        else            in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            me_v[k]  = det_me;
            mo_v[k]  = det_mo;
            rdy_v[k] = in_ready;
            bsy_v[k] = busy & bit_en;
            irq_v[k] = irq;
            bit_v[k] = det_bit;
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vec++;
        if ({in_ready, busy, bit_en, det_bit, det_mo, det_me, irq} !== 7'b0) begin
            err++;
            $display("FAIL reset_outputs got %b exp 0000000",
                     {in_ready, busy, bit_en, det_bit, det_mo, det_me, irq});
        end
        vec++;
        if (match_cnt !== 8'd0) begin
            err++;
            $display("FAIL reset_cnt got %0d exp 0", match_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            err++;
            $display("FAIL post_reset rdy/busy got %b%b exp 10", in_ready, busy);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] me, mo, rdy, bsy, iq, bv;
        shift_word(8'hD8, 1'b0, 8'h00, me, mo, rdy, bsy, iq, bv);
        vec++;
        if (me !== 8'h24) begin
            err++;
            $display("FAIL single_me got %h exp 24", me);
        end
        vec++;
        if (mo !== 8'h48) begin
            err++;
            $display("FAIL single_mo got %h exp 48", mo);
        end
        vec++;
        if (bv !== 8'h1B) begin
            err++;
            $display("FAIL single_bits got %h exp 1b", bv);
        end
        vec++;
        if (bsy !== 8'hFF) begin
            err++;
            $display("FAIL single_busy got %h exp ff", bsy);
        end
        @(negedge clk);
        vec++;
        if (match_cnt !== 8'd2 || irq !== 1'b0 || busy !== 1'b0) begin
            err++;
            $display("FAIL single_end cnt/irq/busy got %0d/%b/%b exp 2/0/0",
                     match_cnt, irq, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] me1, mo1, rdy1, bsy1, iq1, bv1;
        logic [7:0] me2, mo2, rdy2, bsy2, iq2, bv2;
        do_clr();
        shift_word(8'h03, 1'b1, 8'h00, me1, mo1, rdy1, bsy1, iq1, bv1);
        shift_word(8'h00, 1'b0, 8'h00, me2, mo2, rdy2, bsy2, iq2, bv2);
        vec++;
        if (rdy1 !== 8'h80) begin
            err++;
            $display("FAIL b2b_ready got %h exp 80", rdy1);
        end
        vec++;
        if (bsy2 !== 8'hFF) begin
            err++;
            $display("FAIL b2b_gapless got %h exp ff", bsy2);
        end
        vec++;
        if (me1 !== 8'h00 || me2 !== 8'h01) begin
            err++;
            $display("FAIL b2b_me got %h/%h exp 00/01", me1, me2);
        end
        vec++;
        if (mo2 !== 8'h02) begin
            err++;
            $display("FAIL b2b_mo got %h exp 02", mo2);
        end
        @(negedge clk);
        vec++;
        if (match_cnt !== 8'd1) begin
            err++;
            $display("FAIL b2b_cnt got %0d exp 1", match_cnt);
        end
    endtask

    task automatic test_threshold();
        logic [7:0] me, mo, rdy, bsy, iq, bv;
        do_clr();
        thresh = 8'd3;
        shift_word(8'hDB, 1'b0, 8'h00, me, mo, rdy, bsy, iq, bv);
        @(negedge clk);
        vec++;
        if (match_cnt !== 8'd2 || irq !== 1'b0) begin
            err++;
            $display("FAIL thr_first cnt/irq got %0d/%b exp 2/0", match_cnt, irq);
        end
        shift_word(8'h60, 1'b0, 8'h00, me, mo, rdy, bsy, iq, bv);
        vec++;
        if (iq !== 8'hFE) begin
            err++;
            $display("FAIL thr_irq_edge got %h exp fe", iq);
        end
        @(negedge clk);
        vec++;
        if (match_cnt !== 8'd4 || irq !== 1'b1) begin
            err++;
            $display("FAIL thr_final cnt/irq got %0d/%b exp 4/1", match_cnt, irq);
        end
        do_clr();
        vec++;
        if (match_cnt !== 8'd0 || irq !== 1'b0) begin
            err++;
            $display("FAIL thr_clr cnt/irq got %0d/%b exp 0/0", match_cnt, irq);
        end
    endtask

    task automatic test_clr_collision();
        thresh = 8'd1;
        in_valid = 1'b1;
        in_data  = 8'h06;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(negedge clk);
        vec++;
        if (det_me !== 1'b1) begin
            err++;
            $display("FAIL collide_me got %b exp 1", det_me);
        end
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        vec++;
        if (match_cnt !== 8'd0 || irq !== 1'b0) begin
            err++;
            $display("FAIL collide_cnt cnt/irq got %0d/%b exp 0/0", match_cnt, irq);
        end
        thresh = 8'd0;
    endtask

    task automatic test_saturation();
        logic [7:0] me, mo, rdy, bsy, iq, bv;
        do_clr();
        for (int i = 0; i < 3; i++)
            shift_word(8'hB6, 1'b0, 8'h00, me, mo, rdy, bsy, iq, bv);
        @(negedge clk);
        vec++;
        if (s_match_cnt !== 2'd3) begin
            err++;
            $display("FAIL sat_cnt got %0d exp 3", s_match_cnt);
        end
        vec++;
        if (match_cnt !== 8'd6) begin
            err++;
            $display("FAIL sat_wide_cnt got %0d exp 6", match_cnt);
        end
    endtask

    task automatic test_abort();
        logic [7:0] me, mo, rdy, bsy, iq, bv;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        vec++;
        if ({in_ready, busy, bit_en, det_bit, det_mo, det_me, irq} !== 7'b0
            || match_cnt !== 8'd0) begin
            err++;
            $display("FAIL abort_reset got %b cnt %0d exp 0000000 cnt 0",
                     {in_ready, busy, bit_en, det_bit, det_mo, det_me, irq}, match_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        shift_word(8'h40, 1'b0, 8'h00, me, mo, rdy, bsy, iq, bv);
        vec++;
        if (me !== 8'h00 || mo !== 8'h00) begin
            err++;
            $display("FAIL abort_next me/mo got %h/%h exp 00/00", me, mo);
        end
        @(negedge clk);
        vec++;
        if (match_cnt !== 8'd0 || busy !== 1'b0) begin
            err++;
            $display("FAIL abort_end cnt/busy got %0d/%b exp 0/0", match_cnt, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_threshold();
        test_clr_collision();
        test_saturation();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
